// File: rtl/vdmem_if.sv
// vdmem_if: M-stage scalar/vector memory bus between the kodd core and vdmem_ctrl.
interface vdmem_if #(parameter int LANES = 4);
  logic                    MemReadM;
  logic                    MemWriteM;
  logic [31:0]             DataAdrM;
  logic [31:0]             WriteDataM;
  logic [31:0]             ReadDataM;
  logic                    MemReadVecM;
  logic                    MemWriteVecM;
  logic [LANES-1:0][31:0]  DataAdrVecM;
  logic [LANES-1:0][31:0]  WriteDataMVec;
  logic [LANES-1:0][31:0]  ReadDataVecM;
  logic                    StallM;
  logic                    DoneM;
  modport master (
    output MemReadM, MemWriteM, DataAdrM, WriteDataM,
    output MemReadVecM, MemWriteVecM, DataAdrVecM, WriteDataMVec,
    input  ReadDataM, ReadDataVecM, StallM, DoneM
  );
  modport slave (
    input  MemReadM, MemWriteM, DataAdrM, WriteDataM,
    input  MemReadVecM, MemWriteVecM, DataAdrVecM, WriteDataMVec,
    output ReadDataM, ReadDataVecM, StallM, DoneM
  );
endinterface

// File: rtl/vdmem_ctrl.sv
// vdmem_ctrl: single-port word RAM serving scalar and 4-lane vector loads/stores,
// one lane per cycle, stalling the M stage until a one-cycle DoneM pulse.
module vdmem_ctrl #(
  parameter int DEPTH = 256,
  parameter int LANES = 4
) (
  input  logic clk,
  input  logic reset,
  vdmem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(LANES);
  typedef enum logic [1:0] {IDLE, ACC, VEC, DONE} state_t;
  state_t                   state_q;
  logic [LW-1:0]            lane_q;
  logic                     wr_q;
  logic                     done_q;
  logic [LANES-1:0][AW-1:0] adr_q;
  logic [LANES-1:0][31:0]   dat_q;
  logic [LANES-1:0][31:0]   rdv_q;
  logic [31:0]              rd_q;
  logic [31:0]              mem [DEPTH];
  logic                     any_vec;
  logic                     any_req;
  logic                     busy;
  logic [AW-1:0]            idx;
  logic                     unused_adr;
  assign any_vec = bus.MemWriteVecM | bus.MemReadVecM;
  assign any_req = any_vec | bus.MemWriteM | bus.MemReadM;
  assign busy    = state_q == ACC || state_q == VEC;
  // scalar accesses always live in slot 0, so lane_q (held at 0) selects them too
  assign idx     = adr_q[lane_q];
  assign unused_adr = ^{bus.DataAdrM, bus.DataAdrVecM};
  assign bus.StallM       = !reset && (state_q == IDLE ? any_req : busy);
  assign bus.DoneM        = done_q;
  assign bus.ReadDataM    = rd_q;
  assign bus.ReadDataVecM = rdv_q;
  always_ff @(posedge clk)
    if (busy && wr_q && !reset) mem[idx] <= dat_q[lane_q];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lane_q  <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdv_q   <= '0;
      rd_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (any_req) begin
          wr_q   <= any_vec ? bus.MemWriteVecM : bus.MemWriteM;
          lane_q <= '0;
          if (any_vec) begin
            for (int i = 0; i < LANES; i++) adr_q[i] <= bus.DataAdrVecM[i][AW+1:2];
            dat_q   <= bus.WriteDataMVec;
            state_q <= VEC;
          end else begin
            adr_q[0] <= bus.DataAdrM[AW+1:2];
            dat_q[0] <= bus.WriteDataM;
            state_q  <= ACC;
          end
        end
        ACC: begin
          if (!wr_q) rd_q <= mem[idx];
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        VEC: begin
          if (!wr_q) rdv_q[lane_q] <= mem[idx];
          lane_q <= lane_q + 1'b1;
          if (lane_q == LW'(LANES - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vdmem_ctrl.sv
// tb_vdmem_ctrl: directed table of scalar/vector accesses plus reset-mid-vector sequence.
module tb_vdmem_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  vdmem_if bus ();
  vdmem_ctrl #(.DEPTH(256), .LANES(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]   req;
    logic [31:0]  adr;
    logic [31:0]  wd;
    logic [127:0] va;
    logic [127:0] vd;
    logic [31:0]  erd;
    logic [127:0] erv;
    int           est;
  } rec_t;
  rec_t tbl[$];
  function automatic rec_t mk(logic [3:0] req, logic [31:0] adr, logic [31:0] wd,
                              logic [127:0] va, logic [127:0] vd,
                              logic [31:0] erd, logic [127:0] erv, int est);
    rec_t r;
    r.req = req; r.adr = adr; r.wd = wd; r.va = va; r.vd = vd;
    r.erd = erd; r.erv = erv; r.est = est;
    return r;
  endfunction
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(logic [3:0] req, logic [31:0] adr, logic [31:0] wd,
                       logic [127:0] va, logic [127:0] vd);
    {bus.MemWriteVecM, bus.MemReadVecM, bus.MemWriteM, bus.MemReadM} = req;
    bus.DataAdrM = adr;
    bus.WriteDataM = wd;
    bus.DataAdrVecM = va;
    bus.WriteDataMVec = vd;
  endtask
  // request is held through DONE and into the following IDLE cycle, then dropped
  task automatic op(string name, rec_t r);
    int stalls;
    int n;
    drive(r.req, r.adr, r.wd, r.va, r.vd);
    #1;
    stalls = 0;
    n = 0;
    while (!bus.DoneM && n < 20) begin
      stalls += int'(bus.StallM);
      @(negedge clk); #1;
      n++;
    end
    chk({name, " done"}, 128'(bus.DoneM), 128'(1));
    chk({name, " stall_in_done"}, 128'(bus.StallM), 128'(0));
    chk({name, " stall_cycles"}, 128'(stalls), 128'(r.est));
    chk({name, " rd"}, 128'(bus.ReadDataM), 128'(r.erd));
    chk({name, " rdv"}, bus.ReadDataVecM, r.erv);
    @(negedge clk); #1;
    chk({name, " done_pulse"}, 128'(bus.DoneM), 128'(0));
    drive(4'b0, 32'h0, 32'h0, 128'h0, 128'h0);
    #1;
    chk({name, " idle_stall"}, 128'(bus.StallM), 128'(0));
    @(negedge clk); #1;
    chk({name, " idle_quiet"}, 128'({bus.StallM, bus.DoneM}), 128'(0));
  endtask
  localparam logic [3:0] WV = 4'b1000, RV = 4'b0100, WS = 4'b0010, RS = 4'b0001;
  initial begin
    rec_t r;
    tbl.push_back(mk(WS, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 0, 2));
    tbl.push_back(mk(RS, 32'h10, 0, 0, 0, 32'hDEADBEEF, 0, 2));
    tbl.push_back(mk(WV, 0, 0, {32'hC, 32'h8, 32'h4, 32'h0}, {32'd4, 32'd3, 32'd2, 32'd1},
                     32'hDEADBEEF, 0, 5));
    tbl.push_back(mk(RV, 0, 0, {32'hC, 32'h8, 32'h4, 32'h0}, 0,
                     32'hDEADBEEF, {32'd4, 32'd3, 32'd2, 32'd1}, 5));
    tbl.push_back(mk(WV, 0, 0, {4{32'h20}}, {32'hD, 32'hC, 32'hB, 32'hA},
                     32'hDEADBEEF, {32'd4, 32'd3, 32'd2, 32'd1}, 5));
    tbl.push_back(mk(RS, 32'h20, 0, 0, 0, 32'hD, {32'd4, 32'd3, 32'd2, 32'd1}, 2));
    tbl.push_back(mk(WS, 32'h400, 32'h55, 0, 0, 32'hD, {32'd4, 32'd3, 32'd2, 32'd1}, 2));
    tbl.push_back(mk(RS, 32'h0, 0, 0, 0, 32'h55, {32'd4, 32'd3, 32'd2, 32'd1}, 2));
    tbl.push_back(mk(WS, 32'h13, 32'h66, 0, 0, 32'h55, {32'd4, 32'd3, 32'd2, 32'd1}, 2));
    tbl.push_back(mk(RS, 32'h10, 0, 0, 0, 32'h66, {32'd4, 32'd3, 32'd2, 32'd1}, 2));
    tbl.push_back(mk(RV, 0, 0, {32'h8, 32'h20, 32'h10, 32'h400}, 0,
                     32'h66, {32'h3, 32'hD, 32'h66, 32'h55}, 5));
    tbl.push_back(mk(WS | RS, 32'h30, 32'h11, 0, 0, 32'h66, {32'h3, 32'hD, 32'h66, 32'h55}, 2));
    tbl.push_back(mk(RS, 32'h30, 0, 0, 0, 32'h11, {32'h3, 32'hD, 32'h66, 32'h55}, 2));
    tbl.push_back(mk(WS, 32'h34, 32'h22, 0, 0, 32'h11, {32'h3, 32'hD, 32'h66, 32'h55}, 2));
    tbl.push_back(mk(RV | WS, 32'h34, 32'hBAD, {32'h30, 32'h34, 32'h10, 32'h4}, 0,
                     32'h11, {32'h11, 32'h22, 32'h66, 32'h2}, 5));
    tbl.push_back(mk(RS, 32'h34, 0, 0, 0, 32'h22, {32'h11, 32'h22, 32'h66, 32'h2}, 2));
    tbl.push_back(mk(WV | RV, 0, 0, {32'h5C, 32'h58, 32'h54, 32'h50}, {32'd9, 32'd8, 32'd7, 32'd6},
                     32'h22, {32'h11, 32'h22, 32'h66, 32'h2}, 5));
    tbl.push_back(mk(RV, 0, 0, {32'h5C, 32'h58, 32'h54, 32'h50}, 0,
                     32'h22, {32'd9, 32'd8, 32'd7, 32'd6}, 5));
    tbl.push_back(mk(RV | RS, 32'h10, 0, {4{32'h0}}, 0, 32'h22, {4{32'h55}}, 5));
    tbl.push_back(mk(WS, 32'h60, 32'h42, 0, 0, 32'h22, {4{32'h55}}, 2));
    tbl.push_back(mk(WV | WS, 32'h60, 32'hFFFF, {32'h6C, 32'h68, 32'h64, 32'h64},
                     {32'd4, 32'd3, 32'd2, 32'd1}, 32'h22, {4{32'h55}}, 5));
    tbl.push_back(mk(RS, 32'h60, 0, 0, 0, 32'h42, {4{32'h55}}, 2));
    tbl.push_back(mk(RV, 0, 0, {32'h6C, 32'h68, 32'h64, 32'h60}, 0,
                     32'h42, {32'h4, 32'h3, 32'h2, 32'h42}, 5));
    tbl.push_back(mk(WS, 32'h48, 32'h99, 0, 0, 32'h42, {32'h4, 32'h3, 32'h2, 32'h42}, 2));
    drive(WS, 32'h10, 32'h1, 0, 0);
    #2;
    chk("reset stall", 128'(bus.StallM), 128'(0));
    chk("reset done", 128'(bus.DoneM), 128'(0));
    chk("reset rd", 128'(bus.ReadDataM), 128'(0));
    chk("reset rdv", bus.ReadDataVecM, 128'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(4'b0, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("idle stall", 128'(bus.StallM), 128'(0));
    foreach (tbl[i]) op($sformatf("vec%0d", i), tbl[i]);
    drive(WV, 0, 0, {32'h4C, 32'h48, 32'h44, 32'h40}, {32'd8, 32'd7, 32'd6, 32'd5});
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst stall", 128'(bus.StallM), 128'(0));
    chk("midrst done", 128'(bus.DoneM), 128'(0));
    chk("midrst rd", 128'(bus.ReadDataM), 128'(0));
    chk("midrst rdv", bus.ReadDataVecM, 128'(0));
    @(negedge clk); #1;
    reset = 1'b0;
    drive(4'b0, 0, 0, 0, 0);
    #1;
    chk("post_rst stall", 128'(bus.StallM), 128'(0));
    @(negedge clk); #1;
    chk("post_rst quiet", 128'({bus.StallM, bus.DoneM}), 128'(0));
    r = mk(RS, 32'h40, 0, 0, 0, 32'd5, 0, 2);
    op("rst_ld40", r);
    r = mk(RS, 32'h44, 0, 0, 0, 32'd6, 0, 2);
    op("rst_ld44", r);
    r = mk(RS, 32'h48, 0, 0, 0, 32'h99, 0, 2);
    op("rst_ld48", r);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
